// File: rtl/puf_pkg.sv
// Shared state encoding and default sizing
// for the arbiter-PUF race launcher.
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_VOTE,
    S_DONE
  } state_t;

  localparam int DEF_CHAL_W    = 16;
  localparam int DEF_RESP_BITS = 8;
  localparam int DEF_SAMPLES   = 5;
  localparam int DEF_ARM_CYC   = 2;
  localparam int DEF_TIMEOUT   = 64;

endpackage

// File: rtl/race_launcher_sync2.sv
// Two-flop synchronizer for one
// asynchronous arbiter signal.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/race_launcher.sv
// Arbiter-PUF race sequencer: arms, fires and
// majority-votes races into a response word.
import puf_pkg::*;

module race_launcher #(
  parameter int CHAL_W    = DEF_CHAL_W,
  parameter int RESP_BITS = DEF_RESP_BITS,
  parameter int SAMPLES   = DEF_SAMPLES,
  parameter int ARM_CYC   = DEF_ARM_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [CHAL_W-1:0]    challenge,
  output logic [CHAL_W-1:0]    chal_out,
  output logic                 launch,
  output logic                 arb_reset,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] response,
  output logic                 resp_err
);

  localparam int AW = $clog2(ARM_CYC + 1);
  localparam int FW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SAMPLES + 1);
  localparam int BW = $clog2(RESP_BITS + 1);

  localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_CYC - 1);
  localparam logic [FW-1:0] FIRE_LAST = FW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES - 1);
  localparam logic [SW-1:0] HALF      = SW'(SAMPLES / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(RESP_BITS - 1);

  state_t              state;
  logic [CHAL_W-1:0]   chal;
  logic [AW-1:0]       arm_cnt;
  logic [FW-1:0]       fire_cnt;
  logic [SW-1:0]       sample_idx;
  logic [SW-1:0]       ones_cnt;
  logic [BW-1:0]       bit_idx;
  logic                sample;
  logic                done_s;
  logic                out_s;
  logic [SW-1:0]       ones_nxt;
  logic                vbit;
  logic [31:0]         rot_n;

  sync2 u_sync_done (
    .clk   (clk),
    .reset (reset),
    .d     (arb_done),
    .q     (done_s)
  );

  sync2 u_sync_out (
    .clk   (clk),
    .reset (reset),
    .d     (arb_out),
    .q     (out_s)
  );

  function automatic logic [CHAL_W-1:0] rotl(
    input logic [CHAL_W-1:0] v,
    input logic [31:0]       n
  );
    logic [2*CHAL_W-1:0] d;
    d = {v, v} << (n % CHAL_W);
    return d[2*CHAL_W-1:CHAL_W];
  endfunction

  always_comb begin
    ones_nxt = ones_cnt + SW'(sample);
    vbit     = ones_nxt > HALF;
    rot_n    = 32'(bit_idx) + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      chal        <= '0;
      chal_out    <= '0;
      arm_cnt     <= '0;
      fire_cnt    <= '0;
      sample_idx  <= '0;
      ones_cnt    <= '0;
      bit_idx     <= '0;
      sample      <= 1'b0;
      response    <= '0;
      resp_err    <= 1'b0;
      resp_valid  <= 1'b0;
      launch      <= 1'b0;
      arb_reset   <= 1'b1;
      start_ready <= 1'b1;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_valid) begin
            chal        <= challenge;
            chal_out    <= challenge;
            bit_idx     <= '0;
            sample_idx  <= '0;
            ones_cnt    <= '0;
            resp_err    <= 1'b0;
            arm_cnt     <= '0;
            start_ready <= 1'b0;
            state       <= S_ARM;
          end
        end
        S_ARM: begin
          // a still-set arbiter must clear before the next race
          if (arm_cnt == ARM_LAST) begin
            if (!done_s) begin
              launch    <= 1'b1;
              arb_reset <= 1'b0;
              fire_cnt  <= '0;
              state     <= S_FIRE;
            end
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        S_FIRE: begin
          if (done_s || fire_cnt == FIRE_LAST) begin
            sample    <= done_s ? out_s : 1'b0;
            resp_err  <= resp_err | ~done_s;
            launch    <= 1'b0;
            arb_reset <= 1'b1;
            state     <= S_VOTE;
          end else begin
            fire_cnt <= fire_cnt + 1'b1;
          end
        end
        S_VOTE: begin
          arm_cnt <= '0;
          state   <= S_ARM;
          if (sample_idx == SAMP_LAST) begin
            ones_cnt   <= '0;
            sample_idx <= '0;
            response   <= {vbit, response[RESP_BITS-1:1]};
            bit_idx    <= bit_idx + 1'b1;
            chal_out   <= rotl(chal, rot_n);
            if (bit_idx == BIT_LAST) begin
              resp_valid <= 1'b1;
              state      <= S_DONE;
            end
          end else begin
            ones_cnt   <= ones_nxt;
            sample_idx <= sample_idx + 1'b1;
          end
        end
        S_DONE: begin
          start_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
